// File: rtl/rv32i_exec_decode.sv
// RV32I single-cycle decode/execute slice: control decode, ALU and
// branch compare, plus a retired-instruction counter.
module rv32i_exec_decode #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  output logic [3:0]      o_alu_op,
  output logic [2:0]      o_imm_sel,
  output logic            o_reg_we,
  output logic            o_mem_we,
  output logic            o_mem_re,
  output logic            o_opa_sel,
  output logic [1:0]      o_opb_sel,
  output logic            o_alu_src_b_is_imm,
  output logic [1:0]      o_wb_sel,
  output logic            o_br_un,
  output logic            o_br_equal,
  output logic            o_br_less,
  output logic            o_pc_src_branch,
  output logic            o_pc_src_jal,
  output logic            o_pc_src_jalr,
  output logic [XLEN-1:0] o_alu_y,
  output logic            o_alu_zero,
  output logic            o_insn_vld,
  output logic [31:0]     o_insn_cnt
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SLL  = 4'd2;
  localparam logic [3:0] OP_SLT  = 4'd3;
  localparam logic [3:0] OP_SLTU = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_OR   = 4'd8;
  localparam logic [3:0] OP_AND  = 4'd9;
  localparam logic [3:0] OP_PASS = 4'd10;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       unused_instr;

  assign opc = i_instr[6:0];
  assign f3  = i_instr[14:12];
  assign f7  = i_instr[31:25];
  assign unused_instr = ^i_instr[24:7];

  logic is_op, is_opi, is_ld, is_st;
  logic is_br, is_jal, is_jalr, is_lui, is_auipc;

  assign is_op    = (opc == 7'b0110011);
  assign is_opi   = (opc == 7'b0010011);
  assign is_ld    = (opc == 7'b0000011);
  assign is_st    = (opc == 7'b0100011);
  assign is_br    = (opc == 7'b1100011);
  assign is_jal   = (opc == 7'b1101111);
  assign is_jalr  = (opc == 7'b1100111);
  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);

  function automatic logic [3:0] f3_op(
    input logic [2:0] fn,
    input logic       alt
  );
    unique case (fn)
      3'b000:  f3_op = alt ? OP_SUB : OP_ADD;
      3'b001:  f3_op = OP_SLL;
      3'b010:  f3_op = OP_SLT;
      3'b011:  f3_op = OP_SLTU;
      3'b100:  f3_op = OP_XOR;
      3'b101:  f3_op = alt ? OP_SRA : OP_SRL;
      3'b110:  f3_op = OP_OR;
      default: f3_op = OP_AND;
    endcase
  endfunction

  logic       r_ok, i_ok, ld_ok, st_ok, br_ok, jr_ok;
  logic       f7_z, f7_alt;

  assign f7_z   = (f7 == 7'b0000000);
  assign f7_alt = (f7 == 7'b0100000);
  assign r_ok   = f7_z |
                  (f7_alt & ((f3 == 3'b000) | (f3 == 3'b101)));
  assign i_ok   = (f3 == 3'b001) ? f7_z :
                  (f3 == 3'b101) ? (f7_z | f7_alt) : 1'b1;
  assign ld_ok  = (f3 != 3'b011) & (f3 != 3'b110) &
                  (f3 != 3'b111);
  assign st_ok  = (f3 == 3'b000) | (f3 == 3'b001) |
                  (f3 == 3'b010);
  assign br_ok  = (f3 != 3'b010) & (f3 != 3'b011);
  assign jr_ok  = (f3 == 3'b000);

  logic [3:0] alu_op;
  logic [2:0] imm_sel;
  logic       vld, reg_we, mem_we, mem_re, opa;
  logic [1:0] opb, wb;
  logic       br_un, br, jal, jalr;

  always_comb begin
    alu_op  = OP_ADD;
    imm_sel = 3'd0;
    vld     = 1'b0;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    opa     = 1'b0;
    opb     = 2'b00;
    wb      = 2'b00;
    br_un   = 1'b0;
    br      = 1'b0;
    jal     = 1'b0;
    jalr    = 1'b0;
    unique case (1'b1)
      is_op: if (r_ok) begin
        vld    = 1'b1;
        reg_we = 1'b1;
        alu_op = f3_op(f3, i_instr[30]);
      end
      is_opi: if (i_ok) begin
        vld    = 1'b1;
        reg_we = 1'b1;
        opb    = 2'b01;
        alu_op = f3_op(f3, (f3 == 3'b101) & f7_alt);
      end
      is_ld: if (ld_ok) begin
        vld    = 1'b1;
        reg_we = 1'b1;
        mem_re = 1'b1;
        opb    = 2'b01;
        wb     = 2'b01;
      end
      is_st: if (st_ok) begin
        vld     = 1'b1;
        mem_we  = 1'b1;
        opb     = 2'b01;
        imm_sel = 3'd1;
      end
      is_br: if (br_ok) begin
        vld     = 1'b1;
        br      = 1'b1;
        opa     = 1'b1;
        opb     = 2'b01;
        imm_sel = 3'd2;
        br_un   = f3[1];
      end
      is_jal: begin
        vld     = 1'b1;
        reg_we  = 1'b1;
        jal     = 1'b1;
        opa     = 1'b1;
        opb     = 2'b01;
        wb      = 2'b10;
        imm_sel = 3'd4;
      end
      is_jalr: if (jr_ok) begin
        vld    = 1'b1;
        reg_we = 1'b1;
        jalr   = 1'b1;
        opb    = 2'b01;
        wb     = 2'b10;
      end
      is_lui: begin
        vld     = 1'b1;
        reg_we  = 1'b1;
        opb     = 2'b01;
        imm_sel = 3'd3;
        alu_op  = OP_PASS;
      end
      is_auipc: begin
        vld     = 1'b1;
        reg_we  = 1'b1;
        opa     = 1'b1;
        opb     = 2'b01;
        imm_sel = 3'd3;
      end
      default: ;
    endcase
  end

  logic eq, lt, taken;

  assign eq = (i_rs1_data == i_rs2_data);
  assign lt = br_un ? (i_rs1_data < i_rs2_data) :
              ($signed(i_rs1_data) < $signed(i_rs2_data));

  always_comb begin
    taken = 1'b0;
    unique case (f3)
      3'b000:  taken = eq;
      3'b001:  taken = ~eq;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = lt;
      3'b111:  taken = ~lt;
      default: taken = 1'b0;
    endcase
  end

  logic [XLEN-1:0] a, b, y;
  logic [4:0]      sh;

  assign a  = opa ? i_pc : i_rs1_data;
  assign sh = b[4:0];

  always_comb begin
    b = i_rs2_data;
    unique case (opb)
      2'b01:   b = i_imm;
      2'b10:   b = XLEN'(4);
      default: b = i_rs2_data;
    endcase
  end

  always_comb begin
    y = '0;
    unique case (alu_op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_SLL:  y = a << sh;
      OP_SLT:  y = XLEN'($signed(a) < $signed(b));
      OP_SLTU: y = XLEN'(a < b);
      OP_XOR:  y = a ^ b;
      OP_SRL:  y = a >> sh;
      OP_SRA:  y = $signed(a) >>> sh;
      OP_OR:   y = a | b;
      OP_AND:  y = a & b;
      OP_PASS: y = b;
      default: y = '0;
    endcase
  end

  assign o_alu_op           = alu_op;
  assign o_imm_sel          = imm_sel;
  assign o_opa_sel          = opa;
  assign o_opb_sel          = opb;
  assign o_alu_src_b_is_imm = (opb == 2'b01);
  assign o_wb_sel           = wb;
  assign o_br_un            = br_un;
  assign o_br_equal         = eq;
  assign o_br_less          = lt;
  assign o_alu_y            = y;
  assign o_alu_zero         = (y == '0);
  assign o_insn_vld         = vld;

  // Side effects are suppressed while reset is held.
  assign o_reg_we        = reg_we & i_rst_n;
  assign o_mem_we        = mem_we & i_rst_n;
  assign o_mem_re        = mem_re & i_rst_n;
  assign o_pc_src_branch = br & taken & i_rst_n;
  assign o_pc_src_jal    = jal & i_rst_n;
  assign o_pc_src_jalr   = jalr & i_rst_n;

  logic [31:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q + {31'b0, vld};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign o_insn_cnt = cnt_q;

endmodule

// File: tb/tb_rv32i_exec_decode.sv
// Randomized bench for rv32i_exec_decode against an
// instruction-level reference model, plus directed checks.
module tb_rv32i_exec_decode;

  logic        clk, rst_n;
  logic [31:0] instr, pc, r1, r2, imm;
  logic [3:0]  alu_op;
  logic [2:0]  imm_sel;
  logic        reg_we, mem_we, mem_re, opa_sel;
  logic [1:0]  opb_sel, wb_sel;
  logic        bimm, br_un, br_eq, br_lt;
  logic        pc_br, pc_jal, pc_jalr;
  logic [31:0] alu_y, insn_cnt;
  logic        alu_zero, insn_vld;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_cnt;

  rv32i_exec_decode #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr),
    .i_pc(pc), .i_rs1_data(r1), .i_rs2_data(r2),
    .i_imm(imm), .o_alu_op(alu_op), .o_imm_sel(imm_sel),
    .o_reg_we(reg_we), .o_mem_we(mem_we), .o_mem_re(mem_re),
    .o_opa_sel(opa_sel), .o_opb_sel(opb_sel),
    .o_alu_src_b_is_imm(bimm), .o_wb_sel(wb_sel),
    .o_br_un(br_un), .o_br_equal(br_eq), .o_br_less(br_lt),
    .o_pc_src_branch(pc_br), .o_pc_src_jal(pc_jal),
    .o_pc_src_jalr(pc_jalr), .o_alu_y(alu_y),
    .o_alu_zero(alu_zero), .o_insn_vld(insn_vld),
    .o_insn_cnt(insn_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  alu_op;
    logic [2:0]  imm_sel;
    logic        reg_we, mem_we, mem_re, opa;
    logic [1:0]  opb, wb;
    logic        br_un, eq, lt, br, jal, jalr;
    logic [31:0] y;
    logic        zero, vld;
  } exp_t;

  function automatic logic [31:0] sem(
    input logic [2:0] f3, input logic alt,
    input logic [31:0] x, input logic [31:0] z
  );
    case (f3)
      3'd0: sem = alt ? x - z : x + z;
      3'd1: sem = x << z[4:0];
      3'd2: sem = 32'($signed(x) < $signed(z));
      3'd3: sem = 32'(x < z);
      3'd4: sem = x ^ z;
      3'd5: sem = alt ? 32'($signed(x) >>> z[4:0])
                      : x >> z[4:0];
      3'd6: sem = x | z;
      default: sem = x & z;
    endcase
  endfunction

  function automatic logic [3:0] code(
    input logic [2:0] f3, input logic alt
  );
    logic [3:0] tbl [8];
    tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    code = tbl[f3];
    if (alt && f3 == 3'd0) code = 4'd1;
    if (alt && f3 == 3'd5) code = 4'd7;
  endfunction

  function automatic exp_t model(
    input logic [31:0] ins, input logic [31:0] p,
    input logic [31:0] x, input logic [31:0] z,
    input logic [31:0] im, input logic rst
  );
    exp_t e;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       alt, lts, ltu;
    e  = '0;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    e.y = x + z;
    lts = $signed(x) < $signed(z);
    ltu = x < z;
    e.eq = (x == z);
    case (op)
      7'h33:
        if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
          e.vld = 1; e.reg_we = 1;
          e.alu_op = code(f3, ins[30]);
          e.y = sem(f3, ins[30], x, z);
        end
      7'h13:
        if (!(f3 == 1 && f7 != 0) &&
            !(f3 == 5 && f7 != 0 && f7 != 7'h20)) begin
          alt = (f3 == 5) && (f7 == 7'h20);
          e.vld = 1; e.reg_we = 1; e.opb = 1;
          e.alu_op = code(f3, alt);
          e.y = sem(f3, alt, x, im);
        end
      7'h03:
        if (f3 inside {0, 1, 2, 4, 5}) begin
          e.vld = 1; e.reg_we = 1; e.mem_re = 1;
          e.opb = 1; e.wb = 1; e.y = x + im;
        end
      7'h23:
        if (f3 <= 2) begin
          e.vld = 1; e.mem_we = 1; e.opb = 1;
          e.imm_sel = 1; e.y = x + im;
        end
      7'h63:
        if (f3 != 2 && f3 != 3) begin
          e.vld = 1; e.opa = 1; e.opb = 1;
          e.imm_sel = 2; e.br_un = f3[1];
          e.y = p + im;
          case (f3)
            0: e.br = e.eq;
            1: e.br = !e.eq;
            4: e.br = lts;
            5: e.br = !lts;
            6: e.br = ltu;
            default: e.br = !ltu;
          endcase
        end
      7'h6F: begin
        e.vld = 1; e.reg_we = 1; e.jal = 1; e.opa = 1;
        e.opb = 1; e.wb = 2; e.imm_sel = 4; e.y = p + im;
      end
      7'h67:
        if (f3 == 0) begin
          e.vld = 1; e.reg_we = 1; e.jalr = 1;
          e.opb = 1; e.wb = 2; e.y = x + im;
        end
      7'h37: begin
        e.vld = 1; e.reg_we = 1; e.opb = 1;
        e.imm_sel = 3; e.alu_op = 10; e.y = im;
      end
      7'h17: begin
        e.vld = 1; e.reg_we = 1; e.opa = 1; e.opb = 1;
        e.imm_sel = 3; e.y = p + im;
      end
      default: ;
    endcase
    e.lt = e.br_un ? ltu : lts;
    e.zero = (e.y == 0);
    if (!rst) begin
      e.reg_we = 0; e.mem_we = 0; e.mem_re = 0;
      e.br = 0; e.jal = 0; e.jalr = 0;
    end
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_cnt <= 0;
    else if (model(instr, pc, r1, r2, imm, rst_n).vld)
      exp_cnt <= exp_cnt + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    e = model(instr, pc, r1, r2, imm, rst_n);
    chk("alu_op", 32'(alu_op), 32'(e.alu_op));
    chk("imm_sel", 32'(imm_sel), 32'(e.imm_sel));
    chk("reg_we", 32'(reg_we), 32'(e.reg_we));
    chk("mem_we", 32'(mem_we), 32'(e.mem_we));
    chk("mem_re", 32'(mem_re), 32'(e.mem_re));
    chk("opa_sel", 32'(opa_sel), 32'(e.opa));
    chk("opb_sel", 32'(opb_sel), 32'(e.opb));
    chk("b_is_imm", 32'(bimm), 32'(e.opb == 1));
    chk("wb_sel", 32'(wb_sel), 32'(e.wb));
    chk("br_un", 32'(br_un), 32'(e.br_un));
    chk("br_equal", 32'(br_eq), 32'(e.eq));
    chk("br_less", 32'(br_lt), 32'(e.lt));
    chk("pc_branch", 32'(pc_br), 32'(e.br));
    chk("pc_jal", 32'(pc_jal), 32'(e.jal));
    chk("pc_jalr", 32'(pc_jalr), 32'(e.jalr));
    chk("alu_y", alu_y, e.y);
    chk("alu_zero", 32'(alu_zero), 32'(e.zero));
    chk("insn_vld", 32'(insn_vld), 32'(e.vld));
    chk("insn_cnt", insn_cnt, exp_cnt);
    chk("pc_onehot", 32'(32'(pc_br) + 32'(pc_jal) + 32'(pc_jalr) > 1), 0);
  end

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] m);
    @(posedge clk);
    #1;
    instr = i; pc = p; r1 = a; r2 = b; imm = m;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rval();
    case ($urandom_range(0, 7))
      0: rval = 32'h0;
      1: rval = 32'h1;
      2: rval = 32'hFFFF_FFFF;
      3: rval = 32'h8000_0000;
      4: rval = 32'h7FFF_FFFF;
      default: rval = $urandom;
    endcase
  endfunction

  initial begin
    logic [6:0] opcs [10];
    opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
             7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
    rst_n = 0;
    instr = 32'h0020_81B3; pc = 0; r1 = 1; r2 = 2; imm = 0;
    @(negedge clk);
    chk("rst_cnt", insn_cnt, 0);
    chk("rst_reg_we", 32'(reg_we), 0);
    chk("rst_vld", 32'(insn_vld), 1);
    @(posedge clk);
    #1;
    instr = 0;
    rst_n = 1;

    drive(32'h0020_81B3, 0, 32'h7FFF_FFFF, 1, 0);
    chk("add_y", alu_y, 32'h8000_0000);
    chk("add_we", 32'(reg_we), 1);
    chk("add_wb", 32'(wb_sel), 0);
    chk("add_vld", 32'(insn_vld), 1);
    drive(32'h0000_0000, 0, 3, 4, 5);
    chk("zero_vld", 32'(insn_vld), 0);
    chk("zero_we", 32'(reg_we), 0);
    drive(32'h4020_81B3, 0, 5, 5, 0);
    chk("sub_y", alu_y, 0);
    chk("sub_zero", 32'(alu_zero), 1);
    drive(32'h0000_A183, 0, 32'h100, 0, 4);
    chk("lw_re", 32'(mem_re), 1);
    chk("lw_wb", 32'(wb_sel), 1);
    drive(32'hFFFF_FFFF, 0, 3, 4, 5);
    chk("ones_vld", 32'(insn_vld), 0);
    chk("ones_en", 32'({reg_we, mem_we, mem_re,
                        pc_br, pc_jal, pc_jalr}), 0);
    drive(32'h0020_A023, 0, 32'h100, 7, 8);
    chk("sw_we", 32'(mem_we), 1);
    chk("sw_reg_we", 32'(reg_we), 0);
    drive(32'h0080_00EF, 32'h100, 0, 0, 8);
    chk("jal_src", 32'(pc_jal), 1);
    chk("jal_wb", 32'(wb_sel), 2);
    chk("jal_imm", 32'(imm_sel), 4);
    chk("jal_y", alu_y, 32'h108);
    drive(32'h0000_0000, 0, 0, 0, 0);
    chk("cnt_five", insn_cnt, 5);
    #2;
    rst_n = 0;
    #1;
    chk("cnt_async_rst", insn_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1;

    drive(32'h4020_D193, 0, 32'h8000_0000, 0, 32'h402);
    chk("srai_y", alu_y, 32'hE000_0000);
    drive(32'h0020_D193, 0, 32'h8000_0000, 0, 32'h402);
    chk("srli_y", alu_y, 32'h2000_0000);
    drive(32'h0020_C463, 0, 32'hFFFF_FFFF, 1, 8);
    chk("blt_less", 32'(br_lt), 1);
    chk("blt_taken", 32'(pc_br), 1);
    drive(32'h0020_E463, 0, 32'hFFFF_FFFF, 1, 8);
    chk("bltu_un", 32'(br_un), 1);
    chk("bltu_less", 32'(br_lt), 0);
    chk("bltu_taken", 32'(pc_br), 0);
    drive(32'h0000_80E7, 32'h200, 32'h300, 0, 4);
    chk("jalr_src", 32'(pc_jalr), 1);
    chk("jalr_opa", 32'(opa_sel), 0);
    chk("jalr_y", alu_y, 32'h304);

    for (int n = 0; n < 4000; n++) begin
      logic [31:0] w;
      logic [31:0] a;
      @(posedge clk);
      #1;
      w = $urandom;
      w[6:0] = opcs[$urandom_range(0, 9)];
      if ($urandom_range(0, 9) == 9) w[6:0] = 7'($urandom);
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = 7'h20;
        default: ;
      endcase
      a = rval();
      instr = w;
      pc = $urandom;
      r1 = a;
      r2 = ($urandom_range(0, 4) == 0) ? a : rval();
      imm = ($urandom_range(0, 1) == 0) ? rval() : $urandom;
      rst_n = ($urandom_range(0, 149) != 0);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32i_exec_decode.md
Name: rv32i_exec_decode

Overview:
- Combinational RV32I decode and execute slice for the single-cycle CPU: control decoder, ALU and branch comparator in one block.
- Takes the fetched instruction, PC, register-file read data and the immediate already produced by the immediate generator.
- Produces datapath selects, write enables, ALU result and next-PC source selects.
- Holds a retired-instruction counter, its only state.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_instr  in  32  current instruction
- i_pc  in  32  current PC
- i_rs1_data  in  32  rs1 read data
- i_rs2_data  in  32  rs2 read data
- i_imm  in  32  sign-extended immediate from the immediate generator
- o_alu_op  out  4  ALU operation
- o_imm_sel  out  3  immediate format: 0=I, 1=S, 2=B, 3=U, 4=J
- o_reg_we  out  1  register-file write enable
- o_mem_we  out  1  store enable
- o_mem_re  out  1  load enable
- o_opa_sel  out  1  ALU A source: 0=rs1, 1=PC
- o_opb_sel  out  2  ALU B source: 00=rs2, 01=imm, 10=constant 4
- o_alu_src_b_is_imm  out  1  equals (o_opb_sel==01)
- o_wb_sel  out  2  writeback source: 00=ALU, 01=load data, 10=PC+4
- o_br_un  out  1  unsigned compare select
- o_br_equal  out  1  rs1 == rs2
- o_br_less  out  1  rs1 < rs2 (signed or unsigned per o_br_un)
- o_pc_src_branch  out  1  branch taken
- o_pc_src_jal  out  1  JAL
- o_pc_src_jalr  out  1  JALR
- o_alu_y  out  32  ALU result
- o_alu_zero  out  1  o_alu_y == 0
- o_insn_vld  out  1  instruction is a legal RV32I base op
- o_insn_cnt  out  32  count of valid instructions retired

Behaviour:
- All outputs except o_insn_cnt are purely combinational from the inputs.
- While i_rst_n=0, o_reg_we, o_mem_we, o_mem_re and o_pc_src_* are forced 0.

ALU operands:
- A = o_opa_sel ? i_pc : i_rs1_data.
- B = rs2, i_imm or 4, per o_opb_sel.

ALU ops:
- 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- Codes 11-15 give result 0.
- Shift amount is B[4:0]; add/sub wrap modulo 2^32.
- SLT/SLTU produce 0 or 1.

Branch comparator:
- Equal compare is exact.
- Less compare is signed when o_br_un=0, unsigned when 1.

Decode by opcode [6:0]:
- R-type (0110011): o_alu_op from funct3 and instr[30]; opb=00, reg_we=1, wb=00.
  - Legal only if funct7=0000000, or funct7=0100000 with funct3 000 (SUB) or 101 (SRA).
- OP-IMM (0010011): imm I, opb=01, reg_we=1, wb=00.
  - funct3 000 is always ADD.
  - SLLI legal only with funct7=0.
  - funct3 101: funct7=0 gives SRLI, 0100000 gives SRAI, any other funct7 is illegal.
- LOAD (0000011): ADD, imm I, opb=01, mem_re=1, reg_we=1, wb=01. funct3 in {000,001,010,100,101}.
- STORE (0100011): ADD, imm S, opb=01, mem_we=1. funct3 in {000,001,010}.
- BRANCH (1100011): imm B, opa=1, opb=01, ADD; o_br_un = funct3[1]. funct3 010/011 illegal.
  - o_pc_src_branch = taken: BEQ eq, BNE !eq, BLT less, BGE !less, BLTU less, BGEU !less.
- JAL (1101111): imm J, opa=1, opb=01, ADD, reg_we=1, wb=10, pc_src_jal=1.
- JALR (1100111, funct3 000 only): imm I, opa=0, opb=01, ADD, reg_we=1, wb=10, pc_src_jalr=1.
- LUI (0110111): imm U, opb=01, PASS_B, reg_we=1, wb=00.
- AUIPC (0010111): imm U, opa=1, opb=01, ADD, reg_we=1, wb=00.

Rules common to all opcodes:
- rd=x0 does not suppress o_reg_we; the register file discards x0 writes.
- Illegal or unknown encoding: o_insn_vld=0 and all enables and pc_src_* = 0.
- Selects on an illegal encoding default to alu_op=ADD, opa=0, opb=00, wb=00, imm_sel=0, br_un=0.
- At most one pc_src_* is high at any time.

Counter:
- o_insn_cnt resets asynchronously to 0.
- Increments by 1 on each rising i_clk edge while i_rst_n=1 and o_insn_vld=1.
- Wraps 0xFFFFFFFF to 0.
- Reset asserted mid-count clears it immediately, independent of the clock.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=0x7FFFFFFF, rs2=1 -> alu_y=0x80000000, reg_we=1, wb=00, insn_vld=1; sub (0x402081B3) with rs1=rs2=5 -> alu_y=0, alu_zero=1.
- srai (0x4020D193), rs1=0x80000000, imm=0x402 -> alu_y=0xE0000000; srli (0x0020D193) with the same operands -> alu_y=0x20000000.
- BLT (0x0020C463), rs1=0xFFFFFFFF, rs2=1 -> br_less=1, pc_src_branch=1; BLTU (0x0020E463) with the same operands -> br_un=1, br_less=0, pc_src_branch=0.
- JAL (0x008000EF), pc=0x100 -> pc_src_jal=1, wb=10, imm_sel=4; JALR (0x000080E7) -> pc_src_jalr=1, opa=0.
- lw (0x0000A183) -> mem_re=1, wb=01; sw (0x0020A023) -> mem_we=1, reg_we=0; 0x00000000 and 0xFFFFFFFF -> insn_vld=0, all enables 0.
- Counter: reset, then 5 valid cycles interleaved with 2 invalid -> o_insn_cnt=5; assert i_rst_n=0 between edges -> 0 immediately.
